// File: rtl/key_click_decoder.sv
// Classifies debounced key presses into single/double/triple clicks within a gap window
// and steps a mode register on each classification.
module key_click_decoder #(
    parameter int unsigned WINDOW = 31_250_000,
    parameter int unsigned MODES  = 4,
    parameter int unsigned MODE_W = 2
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              key_flag,
    output logic              single_click,
    output logic              double_click,
    output logic              triple_click,
    output logic [MODE_W-1:0] mode,
    output logic              busy
);

    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WINDOW - 1);
    localparam logic [MODE_W-1:0] MODE_MAX = MODE_W'(MODES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT1 = 2'd1,
        WAIT2 = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               timeout;

    logic               single_nxt;
    logic               double_nxt;
    logic               triple_nxt;
    logic               busy_nxt;
    logic [MODE_W-1:0]  mode_nxt;

    assign timeout = (cnt == LAST_CNT);

    // State and window counter
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_nxt;
        end
    end

    // Next state; a press wins over a same-cycle timeout
    always_comb begin
        next_state = state;
        cnt_nxt    = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (key_flag) begin
                    next_state = WAIT1;
                end
            end
            WAIT1: begin
                if (key_flag) begin
                    next_state = WAIT2;
                    cnt_nxt    = '0;
                end else if (timeout) begin
                    next_state = IDLE;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WAIT2: begin
                if (key_flag || timeout) begin
                    next_state = IDLE;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                next_state = IDLE;
                cnt_nxt    = '0;
            end
        endcase
    end

    // Classification decode and mode update, registered below
    always_comb begin
        single_nxt = 1'b0;
        double_nxt = 1'b0;
        triple_nxt = 1'b0;
        mode_nxt   = mode;
        busy_nxt   = (next_state != IDLE);
        case (state)
            WAIT1: single_nxt = !key_flag && timeout;
            WAIT2: begin
                triple_nxt = key_flag;
                double_nxt = !key_flag && timeout;
            end
            default: ;
        endcase
        if (single_nxt) begin
            mode_nxt = (mode == MODE_MAX) ? '0 : mode + MODE_W'(1);
        end else if (double_nxt) begin
            mode_nxt = '0;
        end else if (triple_nxt) begin
            mode_nxt = MODE_MAX;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            single_click <= 1'b0;
            double_click <= 1'b0;
            triple_click <= 1'b0;
            busy         <= 1'b0;
            mode         <= '0;
        end else begin
            single_click <= single_nxt;
            double_click <= double_nxt;
            triple_click <= triple_nxt;
            busy         <= busy_nxt;
            mode         <= mode_nxt;
        end
    end

endmodule

// File: tb/tb_key_click_decoder.sv
// Directed bench for key_click_decoder with WINDOW=10, MODES=4.
module tb_key_click_decoder;

    localparam int unsigned WINDOW = 10;
    localparam int unsigned MODES  = 4;
    localparam int unsigned MODE_W = 2;

    logic              sysclk = 1'b0;
    logic              rst_n;
    logic              key_flag;
    logic              single_click;
    logic              double_click;
    logic              triple_click;
    logic [MODE_W-1:0] mode;
    logic              busy;

    key_click_decoder #(
        .WINDOW (WINDOW),
        .MODES  (MODES),
        .MODE_W (MODE_W)
    ) dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .key_flag     (key_flag),
        .single_click (single_click),
        .double_click (double_click),
        .triple_click (triple_click),
        .mode         (mode),
        .busy         (busy)
    );

    always #5 sysclk = ~sysclk;

    // kf is the input for one cycle; the rest are outputs expected right after that cycle's edge
    typedef struct packed {
        logic       kf;
        logic       s;
        logic       d;
        logic       t;
        logic       b;
        logic [1:0] m;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic logic [5:0] outs();
        return {single_click, double_click, triple_click, busy, mode};
    endfunction

    function automatic void add(input logic kf, input logic s, input logic d,
                                input logic t, input logic b, input logic [1:0] m);
        vec_t v;
        v.kf = kf; v.s = s; v.d = d; v.t = t; v.b = b; v.m = m;
        vecs.push_back(v);
    endfunction

    function automatic void add_busy(input int n, input logic [1:0] m);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m);
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got s/d/t/busy/mode=%b required %b", name, act, exp);
    endtask

    task automatic step(input logic kf);
        @(negedge sysclk);
        key_flag = kf;
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge sysclk);
        rst_n = 1'b0;
        key_flag = 1'b0;
        @(negedge sysclk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b1;
        key_flag = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("reset_async", outs(), 6'b000000);
        @(negedge sysclk);
        rst_n = 1'b1;

        // Single: press at 0, pulse after edge 10, mode 0->1
        add(1'b1, 0, 0, 0, 1, 2'd0);
        add_busy(9, 2'd0);
        add(1'b0, 1, 0, 0, 0, 2'd1);
        add(1'b0, 0, 0, 0, 0, 2'd1);
        // Double: presses at 0 and 5, pulse after edge 15, mode -> 0
        add(1'b1, 0, 0, 0, 1, 2'd1);
        add_busy(4, 2'd1);
        add(1'b1, 0, 0, 0, 1, 2'd1);
        add_busy(9, 2'd1);
        add(1'b0, 0, 1, 0, 0, 2'd0);
        add(1'b0, 0, 0, 0, 0, 2'd0);
        // Triple: presses at 0, 3, 6, pulse right after third, mode -> 3
        add(1'b1, 0, 0, 0, 1, 2'd0);
        add_busy(2, 2'd0);
        add(1'b1, 0, 0, 0, 1, 2'd0);
        add_busy(2, 2'd0);
        add(1'b1, 0, 0, 1, 0, 2'd3);
        add(1'b0, 0, 0, 0, 0, 2'd3);
        // Second press exactly on the timeout cycle: no single, double 10 later
        add(1'b1, 0, 0, 0, 1, 2'd3);
        add_busy(9, 2'd3);
        add(1'b1, 0, 0, 0, 1, 2'd3);
        add_busy(9, 2'd3);
        add(1'b0, 0, 1, 0, 0, 2'd0);
        add(1'b0, 0, 0, 0, 0, 2'd0);
        // Press in IDLE on the cycle right after a single starts a new sequence
        add(1'b1, 0, 0, 0, 1, 2'd0);
        add_busy(9, 2'd0);
        add(1'b0, 1, 0, 0, 0, 2'd1);
        add(1'b1, 0, 0, 0, 1, 2'd1);
        add_busy(9, 2'd1);
        add(1'b0, 1, 0, 0, 0, 2'd2);
        add(1'b0, 0, 0, 0, 0, 2'd2);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].kf);
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].s, vecs[i].d, vecs[i].t, vecs[i].b, vecs[i].m});
        end

        // Four singles from reset: mode 1,2,3,0
        do_reset();
        check("reset_mode", outs(), 6'b000000);
        for (int n = 0; n < 4; n++) begin
            logic [1:0] em;
            em = 2'((n + 1) % 4);
            step(1'b1);
            repeat (9) step(1'b0);
            step(1'b0);
            check($sformatf("wrap%0d", n), outs(), {4'b1000, em});
            step(1'b0);
            check($sformatf("wrap_idle%0d", n), outs(), {4'b0000, em});
        end

        // Triple to mode 3, then reset mid-sequence discards it
        step(1'b1); step(1'b1); step(1'b1);
        check("pre_reset_triple", outs(), 6'b001011);
        step(1'b0);
        step(1'b1);
        step(1'b0); step(1'b0); step(1'b0);
        @(negedge sysclk);
        rst_n = 1'b0;
        #1 check("reset_midseq", outs(), 6'b000000);
        @(posedge sysclk);
        @(posedge sysclk);
        @(negedge sysclk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step(1'b0);
            check($sformatf("post_reset%0d", i), outs(), 6'b000000);
        end
        step(1'b1);
        for (int i = 0; i < 9; i++) begin
            step(1'b0);
            check($sformatf("fresh_busy%0d", i), outs(), 6'b000100);
        end
        step(1'b0);
        check("fresh_single", outs(), 6'b100001);

        // Reset acts without a clock edge
        step(1'b0);
        @(negedge sysclk);
        #2 rst_n = 1'b0;
        #1 check("reset_no_clock", outs(), 6'b000000);
        #1 rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
